// File: rtl/register_file.sv
// RV32I general-purpose register file: two combinational read ports and one
// synchronous write port, with x0 hardwired to zero.
module register_file #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);

    // One-hot load enables; bit 0 is never built, so x0 writes vanish.
    logic [31:1] wr_en_onehot;
    logic [N-1:0] regs [1:31];

    always_comb begin
        wr_en_onehot = '0;
        for (int k = 1; k < 32; k++) begin
            wr_en_onehot[k] = wr_ena && (wr_addr == 5'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k < 32; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (wr_en_onehot[k]) begin
                    regs[k] <= wr_data;
                end
            end
        end
    end

    // Address 0 matches no entry, so it falls through to the zero default.
    always_comb begin
        rd_data0 = '0;
        rd_data1 = '0;
        for (int k = 1; k < 32; k++) begin
            if (rd_addr0 == 5'(k)) begin
                rd_data0 = regs[k];
            end
            if (rd_addr1 == 5'(k)) begin
                rd_data1 = regs[k];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: array model of the architectural registers,
// per-cycle compare on the falling edge, plus literal directed checks.
module tb_register_file;

    logic        clk;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        wr_ena = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_addr0 = '0;
    logic [31:0] rd_data0;
    logic [4:0]  rd_addr1 = '0;
    logic [31:0] rd_data1;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] model [0:31];

    register_file #(.N(32)) dut (
        .clk(clk),
        .rst(rst),
        .wr_ena(wr_ena),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr0(rd_addr0),
        .rd_data0(rd_data0),
        .rd_addr1(rd_addr1),
        .rd_data1(rd_data1)
    );

    initial begin
        clk = 1'b0;
        wait (run);
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural model: x0 is always zero, others hold the last write.
    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (wr_ena && wr_addr != 0) begin
            model[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        check("cmp_rd0", rd_data0, model[rd_addr0]);
        check("cmp_rd1", rd_data1, model[rd_addr1]);
    end

    task automatic drive(input logic e, input logic [4:0] a,
                         input logic [31:0] d);
        @(posedge clk);
        #2;
        wr_ena = e;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0);
    endtask

    task automatic sweep_pattern(input string name);
        for (int a = 0; a < 32; a++) begin
            logic [31:0] e0;
            logic [31:0] e1;
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(31 - a);
            e0 = (a == 0) ? 32'h0 : (32'hA5A50000 | 32'(a));
            e1 = (a == 31) ? 32'h0 : (32'hA5A50000 | 32'(31 - a));
            #1;
            check({name, "_p0"}, rd_data0, e0);
            check({name, "_p1"}, rd_data1, e1);
        end
    endtask

    initial begin
        // 1: reset pulse with no clock edge, reads during and after
        #1 rst = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(31 - a);
            #1;
            check("rst_during_p0", rd_data0, 32'h0);
            check("rst_during_p1", rd_data1, 32'h0);
        end
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(a);
            #1;
            check("rst_after_p0", rd_data0, 32'h0);
            check("rst_after_p1", rd_data1, 32'h0);
        end
        run = 1'b1;

        // 2: fill x1..x31
        for (int k = 1; k < 32; k++) begin
            drive(1'b1, 5'(k), 32'hA5A50000 | 32'(k));
        end
        idle();
        @(posedge clk);
        #2;
        sweep_pattern("fill");

        // 3: write to x0 is dropped
        drive(1'b1, 5'd0, 32'hDEADBEEF);
        idle();
        @(posedge clk);
        #2;
        rd_addr0 = 5'd0;
        #1;
        check("x0_write", rd_data0, 32'h0);
        sweep_pattern("after_x0");

        // 4: disabled write leaves x7 alone
        drive(1'b0, 5'd7, 32'hFFFFFFFF);
        repeat (4) @(posedge clk);
        #2;
        rd_addr0 = 5'd7;
        rd_addr1 = 5'd7;
        #1;
        check("noena_x7_p0", rd_data0, 32'hA5A50007);
        check("noena_x7_p1", rd_data1, 32'hA5A50007);
        idle();

        // 5: read-during-write, no bypass
        rd_addr0 = 5'd5;
        rd_addr1 = 5'd5;
        drive(1'b1, 5'd5, 32'h12345678);
        #1;
        check("rdw_old_p0", rd_data0, 32'hA5A50005);
        check("rdw_old_p1", rd_data1, 32'hA5A50005);
        @(posedge clk);
        #1;
        check("rdw_new_p0", rd_data0, 32'h12345678);
        check("rdw_new_p1", rd_data1, 32'h12345678);
        idle();

        // 6: asynchronous reset mid-cycle, then recover
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_p0", rd_data0, 32'h0);
        check("midrst_p1", rd_data1, 32'h0);
        drive(1'b1, 5'd9, 32'hCAFEF00D);
        @(posedge clk);
        #2;
        rst = 1'b0;
        wr_ena = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h1;
        rd_addr0 = 5'd3;
        rd_addr1 = 5'd9;
        #1;
        check("rst_ignores_wr", rd_data1, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_x3", rd_data0, 32'h1);
        idle();
        repeat (2) @(posedge clk);
        #6;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
